// File: rtl/i2c_master_wm8731_if.sv
// Handshake between the codec init sequencer and the WM8731 I2C write master.
// The sequencer side uses the master modport and the I2C engine uses the slave modport.
interface i2c_master_wm8731_if #(
    parameter int BITS = 24
);
    logic            start;
    logic [BITS-1:0] data_in;
    logic            busy;
    logic            done;
    logic            ack_error;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  ack_error
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output ack_error
    );
endinterface

// File: rtl/i2c_master_wm8731.sv
// Write-only I2C master for the WM8731 codec: START, BITS/8 bytes MSB-first with an
// ACK slot after each byte, STOP, then a short bus-free gap before reporting done.
module i2c_master_wm8731 #(
    parameter int DIV  = 125,
    parameter int BITS = 24
) (
    input  logic               clk,
    input  logic               reset,
    i2c_master_wm8731_if.slave ctl,
    inout  wire                i2c_sdat,
    output logic               i2c_sclk
);

    localparam int DW = $clog2(DIV);
    localparam int IW = $clog2(BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_BUF   = 3'd5
    } state_t;

    state_t          state_r;
    logic [DW-1:0]   div_r;
    logic [1:0]      q_r;
    logic [IW-1:0]   idx_r;
    logic [BITS-1:0] sh_r;
    logic            scl_r;
    logic            sda_oe_r;
    logic            busy_r;
    logic            done_r;
    logic            ack_err_r;
    logic            tick_s;

    // Open-drain data pin: only ever pulled low or released.
    assign i2c_sdat      = sda_oe_r ? 1'b0 : 1'bz;
    assign i2c_sclk      = scl_r;
    assign ctl.busy      = busy_r;
    assign ctl.done      = done_r;
    assign ctl.ack_error = ack_err_r;
    assign tick_s        = (div_r == DW'(DIV - 1));

    // Transaction FSM; every bus output is set on the tick that enters the quarter it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            div_r     <= '0;
            q_r       <= 2'd0;
            idx_r     <= '0;
            sh_r      <= '0;
            scl_r     <= 1'b1;
            sda_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_err_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state_r == ST_IDLE) begin
                div_r <= '0;
                q_r   <= 2'd0;
                scl_r <= 1'b1;
                if (ctl.start && !busy_r) begin
                    sh_r      <= ctl.data_in;
                    ack_err_r <= 1'b0;
                    busy_r    <= 1'b1;
                    sda_oe_r  <= 1'b1;
                    state_r   <= ST_START;
                end else begin
                    sda_oe_r <= 1'b0;
                end
            end else if (!tick_s) begin
                div_r <= div_r + DW'(1);
            end else begin
                div_r <= '0;
                q_r   <= q_r + 2'd1;
                case (state_r)
                    ST_START: begin
                        // START is only two quarters long; the first bit slot restarts at q0.
                        if (q_r == 2'd1) begin
                            scl_r   <= 1'b0;
                            q_r     <= 2'd0;
                            idx_r   <= IW'(BITS - 1);
                            state_r <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        case (q_r)
                            2'd0: sda_oe_r <= ~sh_r[BITS-1];
                            2'd1: scl_r    <= 1'b1;
                            2'd3: begin
                                scl_r <= 1'b0;
                                sh_r  <= {sh_r[BITS-2:0], 1'b0};
                                if (idx_r[2:0] == 3'd0) begin
                                    state_r <= ST_ACK;
                                end else begin
                                    idx_r <= idx_r - IW'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                    ST_ACK: begin
                        case (q_r)
                            2'd0: sda_oe_r <= 1'b0;
                            2'd1: scl_r    <= 1'b1;
                            2'd2: begin
                                // Anything other than a driven low (high or floating) is a NACK.
                                if (i2c_sdat == 1'b0) begin
                                    ack_err_r <= ack_err_r;
                                end else begin
                                    ack_err_r <= 1'b1;
                                end
                            end
                            2'd3: begin
                                scl_r <= 1'b0;
                                if (ack_err_r || (idx_r == '0)) begin
                                    state_r <= ST_STOP;
                                end else begin
                                    idx_r   <= idx_r - IW'(1);
                                    state_r <= ST_DATA;
                                end
                            end
                            default: ;
                        endcase
                    end
                    ST_STOP: begin
                        case (q_r)
                            2'd0: sda_oe_r <= 1'b1;
                            2'd1: scl_r    <= 1'b1;
                            2'd2: sda_oe_r <= 1'b0;
                            2'd3: state_r  <= ST_BUF;
                            default: ;
                        endcase
                    end
                    ST_BUF: begin
                        if (q_r == 2'd3) begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        scl_r    <= 1'b1;
                        sda_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_wm8731.sv
// Directed and randomized bench for i2c_master_wm8731 with a pull-up and a behavioural I2C slave.
module tb_i2c_master_wm8731;
    localparam int DIV  = 4;
    localparam int BITS = 24;

    logic clk;
    logic reset;
    wire  sda;
    logic sclk;
    logic slv_drive = 1'b0;

    int tests = 0;
    int fails = 0;

    i2c_master_wm8731_if #(.BITS(BITS)) bus ();

    i2c_master_wm8731 #(.DIV(DIV), .BITS(BITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .ctl      (bus.slave),
        .i2c_sdat (sda),
        .i2c_sclk (sclk)
    );

    pullup (sda);
    assign sda = slv_drive ? 1'b0 : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model and bus monitor state
    int         nack_byte = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         rise_t[$];
    logic [7:0] rx_q[$];
    logic [7:0] sr = 8'h00;
    int         bitn = 0;
    int         byte_no = 0;
    logic       in_ack = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;

    // Behavioural I2C slave: watches the pins away from the clock edge.
    always @(negedge clk) begin
        cyc++;
        if (prev_scl && sclk && (prev_sda !== sda)) begin
            if (sda == 1'b0) start_cnt++;
            else stop_cnt++;
            bitn = 0; byte_no = 0; in_ack = 1'b0; slv_drive = 1'b0;
        end
        if (!prev_scl && sclk) begin
            rise_t.push_back(cyc);
            if (!in_ack) begin
                sr = {sr[6:0], sda};
                bitn++;
            end
        end
        if (prev_scl && !sclk) begin
            if (in_ack) begin
                in_ack = 1'b0;
                slv_drive = 1'b0;
            end else if (bitn == 8) begin
                rx_q.push_back(sr);
                byte_no++;
                bitn = 0;
                in_ack = 1'b1;
                slv_drive = (byte_no != nack_byte);
            end
        end
        prev_scl = sclk;
        prev_sda = sda;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: nb=0 -> slave ACKs everything, else NACKs byte nb.
    task automatic run(input logic [23:0] w, input int nb, input int inject, input logic [23:0] alt);
        int lat, s0, p0, r0, nbytes, bad;
        logic [23:0] tmp;
        @(negedge clk);
        nack_byte = nb;
        rx_q.delete();
        s0 = start_cnt; p0 = stop_cnt; r0 = rise_t.size();
        bus.start = 1'b1;
        bus.data_in = w;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.data_in = 24'($urandom);
        chk("busy_on_accept", 32'(bus.busy), 32'd1);
        chk("ack_err_cleared", 32'(bus.ack_error), 32'd0);
        lat = 0;
        while (lat < 2000 && !bus.done) begin
            @(posedge clk); #1;
            lat++;
            if (lat == inject) begin
                bus.start = 1'b1;
                bus.data_in = alt;
            end else begin
                bus.start = 1'b0;
            end
        end
        nbytes = (nb == 0) ? 3 : nb;
        chk("done_latency", 32'(lat), (nb == 0) ? 32'(118 * DIV) : 32'((10 + 36 * nb) * DIV));
        chk("ack_error", 32'(bus.ack_error), (nb == 0) ? 32'd0 : 32'd1);
        chk("byte_count", 32'(rx_q.size()), 32'(nbytes));
        for (int i = 0; i < nbytes; i++) begin
            tmp = w >> (8 * (2 - i));
            chk($sformatf("byte%0d", i + 1), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF_FFFF, 32'(tmp[7:0]));
        end
        chk("start_events", 32'(start_cnt - s0), 32'd1);
        chk("stop_events", 32'(stop_cnt - p0), 32'd1);
        chk("scl_rises", 32'(rise_t.size() - r0), 32'(9 * nbytes + 1));
        bad = 0;
        for (int i = r0 + 1; i < rise_t.size(); i++) begin
            if (rise_t[i] - rise_t[i-1] != 4 * DIV) bad++;
        end
        chk("scl_period_errors", 32'(bad), 32'd0);
        @(posedge clk); #1;
        chk("done_one_clk", 32'(bus.done), 32'd0);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [23:0] w;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.data_in = 24'h000000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 32'(sclk), 32'd1);
        chk("rst_sda", 32'(sda), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ack_err", 32'(bus.ack_error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        run(24'h341E00, 0, -1, 24'h000000);

        for (int k = 1; k <= 3; k++) begin
            w = 24'($urandom);
            if (k == 1) w[23:16] = 8'h34;
            run(w, k, -1, 24'h000000);
        end

        // ack_error is still set here; the next accepted start must clear it.
        w = 24'($urandom);
        run(w, 0, 100, ~w);
        for (int k = 0; k < 3; k++) begin
            run(24'($urandom), 0, -1, 24'h000000);
        end

        // Reset in the middle of byte 2.
        @(negedge clk);
        nack_byte = 0;
        bus.start = 1'b1;
        bus.data_in = 24'($urandom);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (200) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_scl", 32'(sclk), 32'd1);
        chk("midrst_sda", 32'(sda), 32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(posedge clk);
        run(24'($urandom), 0, -1, 24'h000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
